// File: rtl/cmp_pkg.sv
// cmp_pkg: shared trend encodings, FSM state type and comparator result type.
package cmp_pkg;
   localparam logic [1:0] TREND_NONE = 2'b00;
   localparam logic [1:0] TREND_UP = 2'b01;
   localparam logic [1:0] TREND_DOWN = 2'b10;
   localparam logic [1:0] TREND_FLAT = 2'b11;
   localparam logic [3:0] RUN_CNT_MAX = 4'd15;
   // State codes double as the trend encoding of the last classified step
   typedef enum logic [1:0] {
      S_EMPTY = TREND_NONE,
      S_UP = TREND_UP,
      S_DOWN = TREND_DOWN,
      S_FLAT = TREND_FLAT
   } state_t;
   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_t;
endpackage

// File: rtl/cmp_trend_detector_if.sv
// cmp_trend_detector_if: sample stream in, registered trend/min/max results out.
interface cmp_trend_detector_if;
   logic       in_valid;
   logic [3:0] in_data;
   logic       clear;
   logic       out_valid;
   logic [1:0] trend;
   logic [3:0] run_cnt;
   logic       rise_alert;
   logic       fall_alert;
   logic [3:0] max_val;
   logic [3:0] min_val;
   modport master (
      output in_valid, in_data, clear,
      input out_valid, trend, run_cnt, rise_alert, fall_alert, max_val, min_val
   );
   modport slave (
      input in_valid, in_data, clear,
      output out_valid, trend, run_cnt, rise_alert, fall_alert, max_val, min_val
   );
endinterface

// File: rtl/comparator.sv
// comparator: unsigned 4-bit magnitude comparator producing gt/lt/eq flags.
module comparator
   import cmp_pkg::*;
(
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output cmp_t       o_res
);
   assign o_res = '{gt: i_a > i_b, lt: i_a < i_b, eq: i_a == i_b};
endmodule

// File: rtl/cmp_trend_detector.sv
// cmp_trend_detector: classifies each sample against the previous one, counts
// same-direction runs, fires one-shot run alerts and tracks running min/max.
module cmp_trend_detector
   import cmp_pkg::*;
#(
   parameter int RUN_LEN = 3
) (
   input logic clk,
   input logic rst,
   cmp_trend_detector_if.slave bus
);
   localparam logic [3:0] RUN_LEN4 = 4'(RUN_LEN);
   state_t     r_state;
   logic [3:0] r_prev;
   logic       r_first;
   cmp_t       w_prev;
   cmp_t       w_max;
   cmp_t       w_min;
   state_t     w_dir;
   logic [3:0] w_cnt;
   logic       w_unused;
   comparator u_cmp_prev (.i_a(bus.in_data), .i_b(r_prev), .o_res(w_prev));
   comparator u_cmp_max (.i_a(bus.in_data), .i_b(bus.max_val), .o_res(w_max));
   comparator u_cmp_min (.i_a(bus.in_data), .i_b(bus.min_val), .o_res(w_min));
   always_comb begin
      w_dir = w_prev.gt ? S_UP : (w_prev.lt ? S_DOWN : S_FLAT);
      w_cnt = (w_dir != r_state || r_first) ? 4'd1 :
              (bus.run_cnt == RUN_CNT_MAX ? RUN_CNT_MAX : bus.run_cnt + 4'd1);
      w_unused = ^{w_prev.eq, w_max.lt, w_max.eq, w_min.gt, w_min.eq};
   end
   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         r_state        <= S_EMPTY;
         r_prev         <= 4'd0;
         r_first        <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.trend      <= TREND_NONE;
         bus.run_cnt    <= 4'd0;
         bus.rise_alert <= 1'b0;
         bus.fall_alert <= 1'b0;
         bus.max_val    <= 4'd0;
         bus.min_val    <= 4'd0;
      end else begin
         bus.out_valid  <= bus.in_valid;
         bus.rise_alert <= 1'b0;
         bus.fall_alert <= 1'b0;
         if (bus.in_valid && r_state == S_EMPTY) begin
            r_state     <= S_FLAT;
            r_first     <= 1'b1;
            r_prev      <= bus.in_data;
            bus.trend   <= TREND_NONE;
            bus.run_cnt <= 4'd0;
            bus.max_val <= bus.in_data;
            bus.min_val <= bus.in_data;
         end else if (bus.in_valid) begin
            r_state     <= w_dir;
            r_first     <= 1'b0;
            r_prev      <= bus.in_data;
            bus.trend   <= w_dir;
            bus.run_cnt <= w_cnt;
            // Old count already at RUN_LEN means a saturated hold, not a new arrival
            bus.rise_alert <= w_dir == S_UP && w_cnt == RUN_LEN4 && bus.run_cnt != RUN_LEN4;
            bus.fall_alert <= w_dir == S_DOWN && w_cnt == RUN_LEN4 && bus.run_cnt != RUN_LEN4;
            bus.max_val <= w_max.gt ? bus.in_data : bus.max_val;
            bus.min_val <= w_min.lt ? bus.in_data : bus.min_val;
         end
      end
   end
endmodule

// File: tb/tb_cmp_trend_detector.sv
// tb_cmp_trend_detector: directed vectors with hand-computed expectations
// for the default RUN_LEN=3 instance and a RUN_LEN=15 instance.
module tb_cmp_trend_detector;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   cmp_trend_detector_if bif ();
   cmp_trend_detector_if b15 ();
   cmp_trend_detector #(.RUN_LEN(3)) u_dut (.clk(clk), .rst(rst), .bus(bif.slave));
   cmp_trend_detector #(.RUN_LEN(15)) u_dut15 (.clk(clk), .rst(rst), .bus(b15.slave));
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic step(input logic v, input logic [3:0] d, input logic c);
      @(negedge clk);
      bif.in_valid = v;
      bif.in_data = d;
      bif.clear = c;
      @(posedge clk);
      #1;
   endtask
   task automatic exp_all(input string t, input logic ov, input logic [1:0] tr,
                          input logic [3:0] rc, input logic ra, input logic fa,
                          input logic [3:0] mx, input logic [3:0] mn);
      chk({t, ".out_valid"}, int'(bif.out_valid), int'(ov));
      chk({t, ".trend"}, int'(bif.trend), int'(tr));
      chk({t, ".run_cnt"}, int'(bif.run_cnt), int'(rc));
      chk({t, ".rise"}, int'(bif.rise_alert), int'(ra));
      chk({t, ".fall"}, int'(bif.fall_alert), int'(fa));
      chk({t, ".max"}, int'(bif.max_val), int'(mx));
      chk({t, ".min"}, int'(bif.min_val), int'(mn));
   endtask
   initial begin
      bif.in_valid = 1'b0;
      bif.in_data = 4'd0;
      bif.clear = 1'b0;
      b15.in_valid = 1'b0;
      b15.in_data = 4'd0;
      b15.clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_all("reset", 0, 2'b00, 0, 0, 0, 0, 0);
      rst = 1'b0;
      // rising run 5,6,7,8
      step(1, 4'd5, 0); exp_all("up5", 1, 2'b00, 0, 0, 0, 5, 5);
      step(1, 4'd6, 0); exp_all("up6", 1, 2'b01, 1, 0, 0, 6, 5);
      step(1, 4'd7, 0); exp_all("up7", 1, 2'b01, 2, 0, 0, 7, 5);
      step(1, 4'd8, 0); exp_all("up8", 1, 2'b01, 3, 1, 0, 8, 5);
      // 9,7,4,2,2
      step(1, 4'd9, 0); exp_all("up9", 1, 2'b01, 4, 0, 0, 9, 5);
      step(1, 4'd7, 0); exp_all("dn7", 1, 2'b10, 1, 0, 0, 9, 5);
      step(1, 4'd4, 0); exp_all("dn4", 1, 2'b10, 2, 0, 0, 9, 4);
      step(1, 4'd2, 0); exp_all("dn2", 1, 2'b10, 3, 0, 1, 9, 2);
      step(1, 4'd2, 0); exp_all("flat2", 1, 2'b11, 1, 0, 0, 9, 2);
      step(0, 4'd0, 0); exp_all("idle_hold", 0, 2'b11, 1, 0, 0, 9, 2);
      // twenty 0xA after reset
      rst = 1'b1; step(0, 4'd0, 0); rst = 1'b0;
      exp_all("rst2", 0, 2'b00, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         step(1, 4'hA, 0);
         exp_all($sformatf("flatA%0d", k), 1, (k == 1) ? 2'b00 : 2'b11,
                 4'((k - 1 > 15) ? 15 : k - 1), 0, 0, 4'hA, 4'hA);
      end
      // clear together with a valid sample drops it
      rst = 1'b1; step(0, 4'd0, 0); rst = 1'b0;
      step(1, 4'd3, 0); exp_all("c3", 1, 2'b00, 0, 0, 0, 3, 3);
      step(1, 4'd4, 0); exp_all("c4", 1, 2'b01, 1, 0, 0, 4, 3);
      step(1, 4'd5, 0); exp_all("c5", 1, 2'b01, 2, 0, 0, 5, 3);
      step(1, 4'd6, 1); exp_all("clr6", 0, 2'b00, 0, 0, 0, 0, 0);
      step(1, 4'd1, 0); exp_all("after_clr1", 1, 2'b00, 0, 0, 0, 1, 1);
      // gaps between 2,3,4 continue the run from 1
      step(0, 4'd0, 0); exp_all("gap1", 0, 2'b00, 0, 0, 0, 1, 1);
      step(1, 4'd2, 0); exp_all("g2", 1, 2'b01, 1, 0, 0, 2, 1);
      step(0, 4'd9, 0); exp_all("gap2", 0, 2'b01, 1, 0, 0, 2, 1);
      step(1, 4'd3, 0); exp_all("g3", 1, 2'b01, 2, 0, 0, 3, 1);
      step(0, 4'd0, 0); exp_all("gap3", 0, 2'b01, 2, 0, 0, 3, 1);
      step(1, 4'd4, 0); exp_all("g4", 1, 2'b01, 3, 1, 0, 4, 1);
      step(0, 4'd0, 0); exp_all("gap4", 0, 2'b01, 3, 0, 0, 4, 1);
      // ramp 0..15 on the RUN_LEN=15 instance
      for (int v = 0; v <= 15; v++) begin
         @(negedge clk);
         b15.in_valid = 1'b1;
         b15.in_data = 4'(v);
         @(posedge clk);
         #1;
         chk($sformatf("r15.ov%0d", v), int'(b15.out_valid), 1);
         chk($sformatf("r15.tr%0d", v), int'(b15.trend), (v == 0) ? 0 : 1);
         chk($sformatf("r15.rc%0d", v), int'(b15.run_cnt), v);
         chk($sformatf("r15.rise%0d", v), int'(b15.rise_alert), (v == 15) ? 1 : 0);
         chk($sformatf("r15.fall%0d", v), int'(b15.fall_alert), 0);
         chk($sformatf("r15.max%0d", v), int'(b15.max_val), v);
         chk($sformatf("r15.min%0d", v), int'(b15.min_val), 0);
      end
      @(negedge clk);
      b15.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("r15.idle_ov", int'(b15.out_valid), 0);
      chk("r15.idle_rise", int'(b15.rise_alert), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cmp_trend_detector.md
# cmp_trend_detector

Streaming trend monitor for 4-bit samples, placed directly downstream of the team's 4-bit magnitude comparator. It consumes the comparator's greater/lesser/equal flags to classify each new sample against the previous one as rising, falling or flat. It counts consecutive same-direction steps, raises one-shot alerts when a rising or falling run reaches a programmable length, and tracks the running minimum and maximum. All outputs are registered.

## Interface
- `RUN_LEN`, default 3: run length that fires an alert; legal range 2..15.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `clear` input 1: synchronous soft clear, same effect as `rst`; lower priority than `rst`.
- `in_valid` input 1: `in_data` is presented this cycle; no backpressure, so every valid sample is accepted.
- `in_data` input 4: unsigned sample.
- `out_valid` output 1: one-cycle pulse; the registered outputs reflect the sample accepted in the previous cycle.
- `trend` output 2: 00 NONE, 01 UP, 10 DOWN, 11 FLAT.
- `run_cnt` output 4: length of the current same-direction run; saturates at 15.
- `rise_alert` output 1: one-cycle pulse when an UP run reaches `RUN_LEN`.
- `fall_alert` output 1: one-cycle pulse when a DOWN run reaches `RUN_LEN`.
- `max_val` output 4: largest sample since reset or clear.
- `min_val` output 4: smallest sample since reset or clear.

## Operation
- FSM states: EMPTY (no previous sample), UP, DOWN, FLAT. The reset state is EMPTY.
- Accepted sample in EMPTY:
  - `prev`, `max_val` and `min_val` all load `in_data`.
  - `trend` = NONE, `run_cnt` = 0.
  - Next state is FLAT, with an internal first-sample flag set so that `trend` remains NONE until the second sample.
- Accepted sample otherwise: compare `in_data` against `prev`.
  - Greater → direction UP; lesser → DOWN; equal → FLAT.
  - Same direction as the current state: `run_cnt` increments, saturating at 15.
  - Different direction, or the second sample after EMPTY: `run_cnt` = 1.
  - `prev` then loads `in_data`, and the state becomes the new direction.
- Alerts:
  - `rise_alert` fires only on the cycle `run_cnt` transitions to exactly `RUN_LEN` in UP.
  - `fall_alert` follows the same rule in DOWN.
  - An alert never repeats within a run, including at saturation. FLAT never alerts.
  - The two alerts are mutually exclusive.
- Min/max:
  - `max_val` updates when `in_data` > `max_val`; `min_val` updates when `in_data` < `min_val`.
  - Both are evaluated in the same cycle as the trend comparison.
- `in_valid` low: all state holds, `out_valid` = 0, and alerts = 0.
- `clear` or `rst` in the same cycle as `in_valid`: the sample is dropped and the block returns to EMPTY.
- Arithmetic: all comparisons are unsigned 4-bit; no wrap-around is allowed on `run_cnt`.

## Timing
- Latency: 1 cycle from the accepting edge to `out_valid` and the updated outputs.
- Throughput: one sample per cycle; back-to-back samples are required to work.
- Reset values: `out_valid` 0, `trend` 00, `run_cnt` 0, `rise_alert` 0, `fall_alert` 0, `max_val` 0, `min_val` 0, `prev` 0, state EMPTY.
- Reset or clear mid-run: on the next cycle every output holds its reset value, and no partial alert is emitted.
- `trend`, `run_cnt`, `max_val` and `min_val` hold between samples. `out_valid` and the alerts are pulses only.

## Structure
- Shared package `cmp_pkg`:
  - trend encoding constants `TREND_NONE`, `TREND_UP`, `TREND_DOWN`, `TREND_FLAT`;
  - FSM state typedef;
  - `RUN_CNT_MAX` = 15.
- Sub-module: three instances of the existing 4-bit magnitude comparator `comparator`:
  - `in_data` vs `prev`;
  - `in_data` vs `max_val`;
  - `in_data` vs `min_val`.
- Top level: the FSM, the run counter and the output registers.

## Test plan
- Reset, then samples 5, 6, 7, 8 back-to-back:
  - `trend` sequence: NONE, UP, UP, UP.
  - `run_cnt` sequence: 0, 1, 2, 3.
  - `rise_alert` pulses with the 4th `out_valid`.
  - `max_val` = 8, `min_val` = 5.
- Samples 9, 7, 4, 2, 2:
  - `fall_alert` pulses exactly once, with the sample 2 that makes `run_cnt` = 3.
  - The final sample gives `trend` FLAT, `run_cnt` 1, and no alert.
- Twenty samples all equal to 0xA: `run_cnt` saturates at 15 and holds; no alerts fire.
- Ramp 0..15 with `RUN_LEN` = 15: `rise_alert` fires once, on sample 15. `max_val` = 15, `min_val` = 0.
- Samples 3, 4, 5; assert `clear` together with `in_valid`/`in_data` = 6; then send 1:
  - The sample 6 is dropped.
  - After the clear, sample 1 gives `trend` NONE and `max_val` = `min_val` = 1.
- Gaps with `in_valid` low between samples 2, 3, 4: outputs hold, `out_valid` is 0 in the gaps, and the rise alert still fires on sample 4.
